// File: rtl/cbus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_rr_arbiter_pkg
// Description : Shared cache-bus (cbus) request/response types and the
//               arbiter state encoding used by cbus_rr_arbiter and its
//               round-robin picker.
//               Contents:
//                 cbus_req_t  - requester -> bus request (valid + fields)
//                 cbus_resp_t - bus -> requester response (ready, last, data)
//                 arb_state_t - arbiter FSM state (ARB_IDLE / ARB_BUSY)
//                 rr_wrap()   - modulo step used by the round-robin search
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_rr_arbiter_pkg;

    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 32;
    localparam int CBUS_STRB_W = CBUS_DATA_W / 8;
    localparam int CBUS_LEN_W  = 8;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [2:0]             size;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_LEN_W-1:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index reached by stepping 'step' places after 'base' in a ring of 'n'.
    // Explicit modulo so the ring size need not be a power of two.
    function automatic int rr_wrap(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage : cbus_rr_arbiter_pkg
`default_nettype wire

// File: rtl/cbus_rr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : cbus_rr_arbiter_rr_picker
// Description : Combinational round-robin picker. Searches last_grant+1,
//               last_grant+2, ... (modulo NUM_REQ) and returns the first
//               index whose valid bit is set. The port granted last is
//               therefore the lowest priority.
// Ports       : valid      in  NUM_REQ  request valid vector
//               last_grant in  IDX_W    most recently granted index
//               pick       out IDX_W    selected index (0 when none valid)
//               any_valid  out 1        at least one valid bit set
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter_rr_picker
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   pick,
    output logic               any_valid
);

    // Walk the ring from the farthest candidate (last_grant itself) back to
    // the nearest (last_grant+1); the last hit written is the nearest valid
    // index, so no "found" flag is needed.
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (valid[rr_wrap(int'(last_grant), k, NUM_REQ)]) begin
                pick = IDX_W'(rr_wrap(int'(last_grant), k, NUM_REQ));
            end
        end
    end

    assign any_valid = |valid;

endmodule : cbus_rr_arbiter_rr_picker
`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_rr_arbiter
// Description : Round-robin arbiter sharing one cbus master port between
//               NUM_REQ requesters. A grant is held for the whole transaction
//               and released on the last-beat handshake (oresp.ready &&
//               oresp.last). At least one IDLE cycle separates transactions.
// Ports       : clk         in  1                 clock, rising edge
//               resetn      in  1                 async active-low reset
//               ireqs       in  NUM_REQ x req     requester requests
//               iresps      out NUM_REQ x resp    requester responses
//               oreq        out req               shared master request
//               oresp       in  resp              shared master response
//               busy        out 1                 transaction in flight
//               grant_id    out IDX_W             granted index (when busy)
//               stat_grants out NUM_REQ x CNT_W   completed transactions
//               stat_waits  out NUM_REQ x CNT_W   cycles valid but not granted
// Config      : CBUS_ARB_STATS_EN - when defined, instantiates saturating
//               per-port statistics counters; otherwise stat_* read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             resetn,
    input  cbus_req_t        ireqs       [NUM_REQ],
    output cbus_resp_t       iresps      [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id,
    output logic [CNT_W-1:0] stat_grants [NUM_REQ],
    output logic [CNT_W-1:0] stat_waits  [NUM_REQ]
);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [IDX_W-1:0]   r_grant_id;
    logic [IDX_W-1:0]   w_grant_next;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_next;
    logic [NUM_REQ-1:0] w_valid;
    logic [IDX_W-1:0]   w_pick;
    logic               w_any_valid;
    logic               w_last_hs;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
        assign w_valid[gi] = ireqs[gi].valid;
    end

    cbus_rr_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid      (w_valid),
        .last_grant (r_last_grant),
        .pick       (w_pick),
        .any_valid  (w_any_valid)
    );

    // Final beat accepted by the downstream port; ends the transaction.
    assign w_last_hs = (r_state == ARB_BUSY) && oresp.ready && oresp.last;

    // ------------------------------------------------------------------
    // State and grant registers. last_grant resets to the top index so
    // port 0 is first in line after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ARB_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_next;
            r_last_grant <= w_last_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output muxing. Outputs depend only on registered
    // state/grant plus the live inputs; oresp never feeds oreq. Request
    // fields are not latched: the granted requester is forwarded as-is,
    // including a (protocol-violating) dropped valid.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_last_next  = r_last_grant;
        oreq         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end

        case (r_state)
            ARB_IDLE: begin
                if (w_any_valid) begin
                    w_state_next = ARB_BUSY;
                    w_grant_next = w_pick;
                    w_last_next  = w_pick;
                end
            end
            ARB_BUSY: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (r_grant_id == IDX_W'(i)) begin
                        oreq      = ireqs[i];
                        iresps[i] = oresp;
                    end
                end
                if (w_last_hs) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    assign busy     = (r_state == ARB_BUSY);
    assign grant_id = r_grant_id;

    // ------------------------------------------------------------------
    // Optional statistics counters (saturating, never wrap).
    // ------------------------------------------------------------------
`ifdef CBUS_ARB_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [CNT_W-1:0] r_grants;
        logic [CNT_W-1:0] r_waits;
        logic             w_is_granted;

        assign w_is_granted = busy && (r_grant_id == IDX_W'(gi));

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_grants <= '0;
                r_waits  <= '0;
            end else begin
                if (w_is_granted && w_last_hs && (r_grants != c_cnt_max)) begin
                    r_grants <= r_grants + CNT_W'(1);
                end
                if (ireqs[gi].valid && !w_is_granted && (r_waits != c_cnt_max)) begin
                    r_waits <= r_waits + CNT_W'(1);
                end
            end
        end

        assign stat_grants[gi] = r_grants;
        assign stat_waits[gi]  = r_waits;
    end
`else
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_no_stats
        assign stat_grants[gi] = '0;
        assign stat_waits[gi]  = '0;
    end
`endif

endmodule : cbus_rr_arbiter
`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_rr_arbiter
// Description : Self-checking bench for cbus_rr_arbiter (NUM_REQ=3).
//               A vector table (inputs + expected outputs per cycle) is fed
//               through a scoreboard queue; hand sequences cover reset,
//               asynchronous reset mid-burst and the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int CW   = 16;
`ifdef CBUS_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    cbus_req_t  ireqs  [NREQ];
    cbus_resp_t iresps [NREQ];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [1:0] grant_id;
    logic [CW-1:0] stat_grants [NREQ];
    logic [CW-1:0] stat_waits  [NREQ];

    cbus_rr_arbiter #(
        .NUM_REQ (NREQ),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ireqs       (ireqs),
        .iresps      (iresps),
        .oreq        (oreq),
        .oresp       (oresp),
        .busy        (busy),
        .grant_id    (grant_id),
        .stat_grants (stat_grants),
        .stat_waits  (stat_waits)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] valid;
        logic       rdy;
        logic       lst;
        logic       e_busy;
        logic [1:0] e_gid;
        logic       e_ov;
        logic [2:0] e_rdy;
    } vec_t;

    vec_t vecs [$];
    vec_t sb_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [2:0] v, input logic r, input logic l,
                                input logic b, input logic [1:0] g, input logic ov,
                                input logic [2:0] er);
        vec_t e;
        e.valid = v; e.rdy = r; e.lst = l;
        e.e_busy = b; e.e_gid = g; e.e_ov = ov; e.e_rdy = er;
        vecs.push_back(e);
    endfunction

    task automatic drive(input logic [2:0] v, input logic r, input logic l);
        for (int i = 0; i < NREQ; i++) begin
            ireqs[i]        = '0;
            ireqs[i].valid  = v[i];
            ireqs[i].addr   = 32'hA000_0000 + 32'(i);
            ireqs[i].data   = 32'h5000_0000 + 32'(i);
            ireqs[i].len    = 8'(i + 1);
            ireqs[i].strobe = 4'hF;
        end
        oresp.ready = r;
        oresp.last  = l;
        oresp.data  = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b000, 1'b0, 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic check_stats(input string tag, input int g0, input int g1, input int g2,
                               input int w0, input int w1, input int w2);
        int eg [NREQ];
        int ew [NREQ];
        eg[0] = g0; eg[1] = g1; eg[2] = g2;
        ew[0] = w0; ew[1] = w1; ew[2] = w2;
        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("%s grants[%0d]", tag, i), 64'(stat_grants[i]),
                  STATS_ON ? 64'(eg[i]) : 64'd0);
            check($sformatf("%s waits[%0d]", tag, i), 64'(stat_waits[i]),
                  STATS_ON ? 64'(ew[i]) : 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        logic [2:0] act_rdy;

        // -------------------- reset behaviour --------------------
        drive(3'b011, 1'b1, 1'b1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst oreq", 64'(oreq), 64'd0);
        check("rst grant_id", 64'(grant_id), 64'd0);
        for (int i = 0; i < NREQ; i++)
            check($sformatf("rst iresps[%0d]", i), 64'(iresps[i]), 64'd0);
        check_stats("rst", 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        tick();
        @(negedge clk);
        check("post-rst busy", 64'(busy), 64'd1);
        check("post-rst grant_id", 64'(grant_id), 64'd0);

        // -------------------- table-driven vectors --------------------
        add(3'b000, 0, 0, 0, 0, 0, 3'b000);
        add(3'b000, 1, 1, 0, 0, 0, 3'b000);   // ready while idle is ignored
        // fairness: all valid, 1-beat transactions
        for (int k = 0; k < 6; k++) begin
            add(3'b111, 1, 1, 0, 0, 0, 3'b000);
            add(3'b111, 1, 1, 1, 2'(k % 3), 1, 3'(1 << (k % 3)));
        end
        // single beat on port 1, handshake on second busy cycle
        add(3'b010, 0, 0, 0, 0, 0, 3'b000);
        add(3'b010, 0, 0, 1, 1, 1, 3'b000);
        add(3'b010, 1, 1, 1, 1, 1, 3'b010);
        add(3'b000, 0, 0, 0, 0, 0, 3'b000);
        // 8-beat burst on port 0 while port 1 waits
        add(3'b011, 0, 0, 0, 0, 0, 3'b000);
        for (int k = 0; k < 7; k++) add(3'b011, 1, 0, 1, 0, 1, 3'b001);
        add(3'b011, 1, 1, 1, 0, 1, 3'b001);
        add(3'b011, 0, 0, 0, 0, 0, 3'b000);
        add(3'b011, 1, 1, 1, 1, 1, 3'b010);
        // port 2 granted, then drops valid mid-transaction
        add(3'b100, 0, 0, 0, 0, 0, 3'b000);
        add(3'b000, 1, 0, 1, 2, 0, 3'b100);
        add(3'b000, 1, 1, 1, 2, 0, 3'b100);
        add(3'b000, 0, 0, 0, 0, 0, 3'b000);

        do_reset();
        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].valid, vecs[n].rdy, vecs[n].lst);
            sb_q.push_back(vecs[n]);
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("v%0d busy", n), 64'(busy), 64'(e.e_busy));
            if (e.e_busy)
                check($sformatf("v%0d grant_id", n), 64'(grant_id), 64'(e.e_gid));
            check($sformatf("v%0d oreq.valid", n), 64'(oreq.valid), 64'(e.e_ov));
            check($sformatf("v%0d oreq.addr", n), 64'(oreq.addr),
                  e.e_busy ? 64'(32'hA000_0000 + 32'(e.e_gid)) : 64'd0);
            for (int i = 0; i < NREQ; i++) act_rdy[i] = iresps[i].ready;
            check($sformatf("v%0d iresp ready", n), 64'(act_rdy), 64'(e.e_rdy));
            for (int i = 0; i < NREQ; i++)
                check($sformatf("v%0d iresps[%0d]", n, i), 64'(iresps[i]),
                      (e.e_busy && e.e_gid == 2'(i)) ? 64'(oresp) : 64'd0);
            tick();
        end

        // -------------------- async reset mid-burst --------------------
        do_reset();
        drive(3'b001, 1'b0, 1'b0);
        tick();                               // beat 1
        drive(3'b001, 1'b1, 1'b0);
        tick();                               // beat 2
        tick();                               // beat 3
        #1;
        check("mid-burst busy", 64'(busy), 64'd1);
        check("mid-burst oreq.valid", 64'(oreq.valid), 64'd1);
        resetn = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst oreq", 64'(oreq), 64'd0);
        check("async rst iresps[0]", 64'(iresps[0]), 64'd0);
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0);
        resetn = 1'b1;
        tick();

        // -------------------- statistics --------------------
        do_reset();
        check_stats("stats reset", 0, 0, 0, 0, 0, 0);
        drive(3'b011, 1'b0, 1'b0); tick();    // idle: port 0 picked
        drive(3'b011, 1'b1, 1'b0); tick();
        drive(3'b011, 1'b1, 1'b0); tick();
        drive(3'b011, 1'b1, 1'b1); tick();    // port 0 last beat
        drive(3'b010, 1'b0, 1'b0); tick();    // idle: port 1 picked
        drive(3'b010, 1'b1, 1'b1); tick();    // port 1 single beat
        drive(3'b000, 1'b0, 1'b0);
        @(negedge clk);
        check_stats("stats end", 1, 1, 0, 1, 5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cbus_rr_arbiter
`default_nettype wire
